// File: rtl/redirect_ctrl.sv
// Branch-redirect controller: arbitrates mispredict corrections from two
// resolution ports by age, hands one redirect PC to fetch, then flushes.
module redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int THROTTLE_TH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [41:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [41:0] req1_data,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic [7:0]  redir_tag,
    output logic        flush,
    output logic [2:0]  streak,
    output logic        throttle
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     pc_reg, pc_next;
    logic [7:0]      tag_reg, tag_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      streak_reg, streak_next;

    logic            ready;
    logic            acc0, acc1, mis0, mis1, plain0, plain1;
    logic            sel1, sel_any, take;
    logic [31:0]     sel_pc;
    logic [7:0]      sel_tag;
    logic            unused_bits;

    // a is older than b when (b - a) mod 256 lies in 1..127
    function automatic logic is_older(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = b - a;
        return (d != 8'd0) && !d[7];
    endfunction

    assign unused_bits = req0_data[41] ^ req1_data[41];

    assign ready      = (state_reg == IDLE) | ((state_reg == HOLD) & !redir_ready);
    assign req0_ready = ready;
    assign req1_ready = ready;

    assign acc0   = req0_valid & ready;
    assign acc1   = req1_valid & ready;
    assign mis0   = acc0 & req0_data[40];
    assign mis1   = acc1 & req1_data[40];
    assign plain0 = acc0 & !req0_data[40];
    assign plain1 = acc1 & !req1_data[40];

    // Port 0 wins unless port 1 is strictly older (covers the 0/128 ties)
    assign sel1    = mis1 & (!mis0 | is_older(req1_data[7:0], req0_data[7:0]));
    assign sel_any = mis0 | mis1;
    assign sel_pc  = sel1 ? req1_data[39:8] : req0_data[39:8];
    assign sel_tag = sel1 ? req1_data[7:0]  : req0_data[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            tag_reg    <= '0;
            cnt_reg    <= '0;
            streak_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            tag_reg    <= tag_next;
            cnt_reg    <= cnt_next;
            streak_reg <= streak_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        tag_next    = tag_reg;
        cnt_next    = cnt_reg;
        streak_next = streak_reg;
        take        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_any) begin
                    pc_next    = sel_pc;
                    tag_next   = sel_tag;
                    state_next = HOLD;
                    take       = 1'b1;
                end
            end
            HOLD: begin
                if (redir_ready) begin
                    state_next = FLUSH;
                    cnt_next   = CW'(FLUSH_CYCLES - 1);
                end else if (sel_any && is_older(sel_tag, tag_reg)) begin
                    pc_next  = sel_pc;
                    tag_next = sel_tag;
                    take     = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            default: state_next = IDLE;
        endcase
        // Discarded wrong-path mispredicts leave the streak untouched
        if (take)
            streak_next = (streak_reg == 3'd7) ? 3'd7 : streak_reg + 3'd1;
        else if (plain0 | plain1)
            streak_next = 3'd0;
    end

    assign redir_valid = (state_reg == HOLD);
    assign flush       = (state_reg == FLUSH);
    assign redir_pc    = pc_reg;
    assign redir_tag   = tag_reg;
    assign streak      = streak_reg;
    assign throttle    = (streak_reg >= 3'(THROTTLE_TH));
endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: arbitration, HOLD replacement, flush timing,
// streak/throttle and async reset, plus a FLUSH_CYCLES=1 instance.
module tb_redirect_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, redir_ready = 1'b0;
    logic [41:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, redir_valid, flush, throttle;
    logic [31:0] redir_pc;
    logic [7:0]  redir_tag;
    logic [2:0]  streak;

    logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_redir_ready = 1'b0;
    logic [41:0] b_req0_data = '0, b_req1_data = '0;
    logic        b_req0_ready, b_req1_ready, b_redir_valid, b_flush, b_throttle;
    logic [31:0] b_redir_pc;
    logic [7:0]  b_redir_tag;
    logic [2:0]  b_streak;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    redirect_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .redir_tag(redir_tag),
        .flush(flush), .streak(streak), .throttle(throttle)
    );

    redirect_ctrl #(.FLUSH_CYCLES(1), .THROTTLE_TH(4)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_data(b_req0_data),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_data(b_req1_data),
        .redir_valid(b_redir_valid), .redir_ready(b_redir_ready),
        .redir_pc(b_redir_pc), .redir_tag(b_redir_tag),
        .flush(b_flush), .streak(b_streak), .throttle(b_throttle)
    );

    function automatic logic [41:0] pkt(input logic mis, input logic [31:0] pc, input logic [7:0] tag);
        return {1'b0, mis, pc, tag};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle packet on port 0 (port 1 idle), accepted at the next edge
    task automatic send0(input logic mis, input logic [31:0] pc, input logic [7:0] tag);
        req0_valid = 1'b1;
        req0_data  = pkt(mis, pc, tag);
        tick();
        req0_valid = 1'b0;
    endtask

    // Handshake from HOLD, then check the 2-cycle flush and return to IDLE
    task automatic finish_redirect(input string tag);
        redir_ready = 1'b1;
        #1;
        check({tag, "_hs_ready"}, req0_ready, 0);
        tick();
        redir_ready = 1'b0;
        check({tag, "_flush1"}, {redir_valid, flush, req0_ready}, 3'b010);
        tick();
        check({tag, "_flush2"}, {redir_valid, flush, req1_ready}, 3'b010);
        tick();
        check({tag, "_idle"}, {flush, req0_ready}, 2'b01);
    endtask

    initial begin
        // Reset state, observed while rst is still low
        #2;
        check("rst_outputs", {redir_valid, flush, streak, throttle, redir_pc, redir_tag}, '0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b11);
        @(negedge clk);
        rst = 1'b1;

        // Single packet on port 0
        req0_valid = 1'b1;
        req0_data  = pkt(1'b1, 32'h0000_1000, 8'h05);
        #1;
        check("single_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("single_redir", {redir_valid, redir_pc, redir_tag}, {1'b1, 32'h0000_1000, 8'h05});
        check("single_streak", streak, 1);
        finish_redirect("single");

        // FLUSH_CYCLES=1 instance: exactly one flush cycle
        b_req0_valid = 1'b1;
        b_req0_data  = pkt(1'b1, 32'h0000_4444, 8'h44);
        tick();
        b_req0_valid  = 1'b0;
        b_redir_ready = 1'b1;
        tick();
        b_redir_ready = 1'b0;
        check("fc1_flush", {b_redir_valid, b_flush}, 2'b01);
        tick();
        check("fc1_done", {b_flush, b_req0_ready}, 2'b01);

        // Simultaneous mispredicts: 0x0F on port 1 is older than 0x10
        req0_valid = 1'b1; req0_data = pkt(1'b1, 32'hAAAA_0010, 8'h10);
        req1_valid = 1'b1; req1_data = pkt(1'b1, 32'hBBBB_000F, 8'h0F);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("age_p1", {redir_pc, redir_tag}, {32'hBBBB_000F, 8'h0F});
        check("age_p1_streak", streak, 2);
        finish_redirect("age_p1");

        // Tie at distance 128: port 0 wins
        req0_valid = 1'b1; req0_data = pkt(1'b1, 32'h0000_0A00, 8'h00);
        req1_valid = 1'b1; req1_data = pkt(1'b1, 32'h0000_0B80, 8'h80);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("age_tie", {redir_pc, redir_tag}, {32'h0000_0A00, 8'h00});
        finish_redirect("age_tie");

        // Wrap: 0xFE (port 1) is older than 0x02 (port 0)
        req0_valid = 1'b1; req0_data = pkt(1'b1, 32'h0000_0C02, 8'h02);
        req1_valid = 1'b1; req1_data = pkt(1'b1, 32'h0000_0DFE, 8'hFE);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("age_wrap", {redir_pc, redir_tag}, {32'h0000_0DFE, 8'hFE});
        check("age_wrap_streak", {streak, throttle}, {3'd4, 1'b1});
        finish_redirect("age_wrap");

        // Non-mispredict consumed in IDLE: no redirect, streak cleared
        send0(1'b0, 32'h0000_9999, 8'h01);
        check("plain_idle", {redir_valid, streak, throttle}, {1'b0, 3'd0, 1'b0});

        // HOLD replacement and wrong-path discard
        send0(1'b1, 32'h0000_2000, 8'h20);
        check("hold_load", {redir_valid, redir_tag, streak}, {1'b1, 8'h20, 3'd1});
        req1_valid = 1'b1; req1_data = pkt(1'b1, 32'h0000_1C00, 8'h1C);
        tick();
        req1_valid = 1'b0;
        check("hold_replace", {redir_valid, redir_pc, redir_tag, streak},
              {1'b1, 32'h0000_1C00, 8'h1C, 3'd2});
        send0(1'b1, 32'h0000_3000, 8'h30);
        check("hold_discard", {redir_valid, redir_pc, redir_tag, streak},
              {1'b1, 32'h0000_1C00, 8'h1C, 3'd2});

        // Backpressure: six cycles with redir_ready low
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("bp_%0d", i), {redir_valid, flush, redir_pc, redir_tag},
                  {1'b1, 1'b0, 32'h0000_1C00, 8'h1C});
        end
        finish_redirect("bp");

        // Streak/throttle ramp
        send0(1'b0, 32'h0, 8'h00);
        check("ramp_clear", streak, 0);
        for (int i = 1; i <= 5; i++) begin
            send0(1'b1, 32'h0000_5000 + 32'(i), 8'(i));
            check($sformatf("ramp_%0d", i), {streak, throttle}, {3'(i), (i >= 4) ? 1'b1 : 1'b0});
            finish_redirect($sformatf("ramp_%0d", i));
        end
        send0(1'b0, 32'h0, 8'h00);
        check("ramp_zero", {streak, throttle}, {3'd0, 1'b0});
        for (int i = 1; i <= 10; i++) begin
            send0(1'b1, 32'h0000_6000 + 32'(i), 8'(i));
            check($sformatf("sat_%0d", i), streak, (i > 7) ? 7 : i);
            finish_redirect($sformatf("sat_%0d", i));
        end

        // Async reset while in HOLD
        send0(1'b1, 32'h0000_7000, 8'h70);
        check("pre_rst_hold", {redir_valid, streak}, {1'b1, 3'd7});
        #2;
        rst = 1'b0;
        #1;
        check("rst_hold", {redir_valid, flush, streak, throttle, redir_pc, redir_tag}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_hold_ready", {req0_ready, req1_ready}, 2'b11);

        // Async reset while in FLUSH
        send0(1'b1, 32'h0000_8000, 8'h80);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        check("pre_rst_flush", flush, 1);
        rst = 1'b0;
        #1;
        check("rst_flush", {redir_valid, flush, streak, throttle, redir_pc, redir_tag}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_flush_ready", req0_ready, 1);

        // Fresh behaviour after reset
        send0(1'b1, 32'h0000_1000, 8'h05);
        check("fresh", {redir_valid, redir_pc, redir_tag, streak}, {1'b1, 32'h0000_1000, 8'h05, 3'd1});
        finish_redirect("fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
